// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: ALU opcode fields, operand-select encodings
// and register index width.
package riscv_pkg;

  localparam int REG_ADDR_W = 5;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SRL  = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic A_SEL_RS1 = 1'b0;
  localparam logic A_SEL_PC  = 1'b1;
  localparam logic B_SEL_RS2 = 1'b0;
  localparam logic B_SEL_IMM = 1'b1;

endpackage

// File: rtl/fwd_mux.sv
// Per-source operand forwarding: EX/MEM beats WB beats the held value,
// and x0 always reads zero.
module fwd_mux #(
  parameter int DATA_WIDTH = 64,
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] src_addr,
  input  logic [DATA_WIDTH-1:0] held_data,
  input  logic                  exm_valid,
  input  logic                  exm_reg_write,
  input  logic [REG_ADDR_W-1:0] exm_rd_addr,
  input  logic [DATA_WIDTH-1:0] exm_result,
  input  logic                  wb_valid,
  input  logic                  wb_reg_write,
  input  logic [REG_ADDR_W-1:0] wb_rd_addr,
  input  logic [DATA_WIDTH-1:0] wb_result,
  output logic                  wb_hit,
  output logic [DATA_WIDTH-1:0] fwd_data
);

  logic src_nonzero_s;
  logic exm_hit_s;

  assign src_nonzero_s = (src_addr != {REG_ADDR_W{1'b0}});
  assign exm_hit_s = exm_valid && exm_reg_write && (exm_rd_addr == src_addr) && src_nonzero_s;
  assign wb_hit    = wb_valid && wb_reg_write && (wb_rd_addr == src_addr) && src_nonzero_s;

  // Priority select of the forwarded operand value
  always_comb begin
    fwd_data = {DATA_WIDTH{1'b0}};
    if (!src_nonzero_s) begin
      fwd_data = {DATA_WIDTH{1'b0}};
    end else if (exm_hit_s) begin
      fwd_data = exm_result;
    end else if (wb_hit) begin
      fwd_data = wb_result;
    end else begin
      fwd_data = held_data;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: holds one decoded instruction, forwards from
// EX/MEM and WB, selects ALU operands and stalls on load-use.
module id_ex_stage #(
  parameter int DATA_WIDTH = 64,
  parameter int REG_ADDR_W = riscv_pkg::REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_pc,
  input  logic [DATA_WIDTH-1:0] in_rs1_data,
  input  logic [DATA_WIDTH-1:0] in_rs2_data,
  input  logic [DATA_WIDTH-1:0] in_imm,
  input  logic [REG_ADDR_W-1:0] in_rs1_addr,
  input  logic [REG_ADDR_W-1:0] in_rs2_addr,
  input  logic [REG_ADDR_W-1:0] in_rd_addr,
  input  logic [2:0]            in_func3,
  input  logic [6:0]            in_func7,
  input  logic                  in_a_sel,
  input  logic                  in_b_sel,
  input  logic                  in_reg_write,
  input  logic                  in_mem_read,
  input  logic                  in_mem_write,
  input  logic                  flush,
  input  logic                  exm_valid,
  input  logic                  exm_reg_write,
  input  logic                  exm_mem_read,
  input  logic [REG_ADDR_W-1:0] exm_rd_addr,
  input  logic [DATA_WIDTH-1:0] exm_result,
  input  logic                  wb_valid,
  input  logic                  wb_reg_write,
  input  logic [REG_ADDR_W-1:0] wb_rd_addr,
  input  logic [DATA_WIDTH-1:0] wb_result,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] data_rs1,
  output logic [DATA_WIDTH-1:0] data_rs2,
  output logic [DATA_WIDTH-1:0] store_data,
  output logic [2:0]            func3,
  output logic [6:0]            func7,
  output logic [REG_ADDR_W-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] pc,
  output logic                  reg_write,
  output logic                  mem_read,
  output logic                  mem_write
);

  import riscv_pkg::*;

  logic                  held_valid_r;
  logic [DATA_WIDTH-1:0] pc_r;
  logic [DATA_WIDTH-1:0] rs1_data_r;
  logic [DATA_WIDTH-1:0] rs2_data_r;
  logic [DATA_WIDTH-1:0] imm_r;
  logic [REG_ADDR_W-1:0] rs1_addr_r;
  logic [REG_ADDR_W-1:0] rs2_addr_r;
  logic [REG_ADDR_W-1:0] rd_addr_r;
  logic [2:0]            func3_r;
  logic [6:0]            func7_r;
  logic                  a_sel_r;
  logic                  b_sel_r;
  logic                  reg_write_r;
  logic                  mem_read_r;
  logic                  mem_write_r;

  logic [DATA_WIDTH-1:0] fwd_rs1_s;
  logic [DATA_WIDTH-1:0] fwd_rs2_s;
  logic                  wb_hit_rs1_s;
  logic                  wb_hit_rs2_s;
  logic                  rs1_used_s;
  logic                  rs2_used_s;
  logic                  hazard_s;
  logic                  departure_s;
  logic                  capture_s;

  fwd_mux #(.DATA_WIDTH(DATA_WIDTH), .REG_ADDR_W(REG_ADDR_W)) u_fwd_rs1 (
    .src_addr      (rs1_addr_r),
    .held_data     (rs1_data_r),
    .exm_valid     (exm_valid),
    .exm_reg_write (exm_reg_write),
    .exm_rd_addr   (exm_rd_addr),
    .exm_result    (exm_result),
    .wb_valid      (wb_valid),
    .wb_reg_write  (wb_reg_write),
    .wb_rd_addr    (wb_rd_addr),
    .wb_result     (wb_result),
    .wb_hit        (wb_hit_rs1_s),
    .fwd_data      (fwd_rs1_s)
  );

  fwd_mux #(.DATA_WIDTH(DATA_WIDTH), .REG_ADDR_W(REG_ADDR_W)) u_fwd_rs2 (
    .src_addr      (rs2_addr_r),
    .held_data     (rs2_data_r),
    .exm_valid     (exm_valid),
    .exm_reg_write (exm_reg_write),
    .exm_rd_addr   (exm_rd_addr),
    .exm_result    (exm_result),
    .wb_valid      (wb_valid),
    .wb_reg_write  (wb_reg_write),
    .wb_rd_addr    (wb_rd_addr),
    .wb_result     (wb_result),
    .wb_hit        (wb_hit_rs2_s),
    .fwd_data      (fwd_rs2_s)
  );

  // A store consumes rs2 even when the ALU takes the immediate
  assign rs1_used_s = (a_sel_r == A_SEL_RS1);
  assign rs2_used_s = (b_sel_r == B_SEL_RS2) || mem_write_r;
  assign hazard_s   = held_valid_r && exm_valid && exm_mem_read
                      && (exm_rd_addr != {REG_ADDR_W{1'b0}})
                      && ((rs1_used_s && (exm_rd_addr == rs1_addr_r))
                       || (rs2_used_s && (exm_rd_addr == rs2_addr_r)));

  assign out_valid   = held_valid_r && !hazard_s;
  assign departure_s = out_valid && out_ready;
  assign in_ready    = !flush && (!held_valid_r || departure_s);
  assign capture_s   = in_valid && in_ready;

  assign data_rs1   = (a_sel_r == A_SEL_PC)  ? pc_r  : fwd_rs1_s;
  assign data_rs2   = (b_sel_r == B_SEL_IMM) ? imm_r : fwd_rs2_s;
  assign store_data = fwd_rs2_s;
  assign func3      = func3_r;
  assign func7      = func7_r;
  assign rd_addr    = rd_addr_r;
  assign pc         = pc_r;
  assign reg_write  = reg_write_r;
  assign mem_read   = mem_read_r;
  assign mem_write  = mem_write_r;

  // Holding register: capture, departure/flush, and WB refresh while stalled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      held_valid_r <= 1'b0;
      pc_r         <= {DATA_WIDTH{1'b0}};
      rs1_data_r   <= {DATA_WIDTH{1'b0}};
      rs2_data_r   <= {DATA_WIDTH{1'b0}};
      imm_r        <= {DATA_WIDTH{1'b0}};
      rs1_addr_r   <= {REG_ADDR_W{1'b0}};
      rs2_addr_r   <= {REG_ADDR_W{1'b0}};
      rd_addr_r    <= {REG_ADDR_W{1'b0}};
      func3_r      <= 3'b000;
      func7_r      <= 7'b0000000;
      a_sel_r      <= 1'b0;
      b_sel_r      <= 1'b0;
      reg_write_r  <= 1'b0;
      mem_read_r   <= 1'b0;
      mem_write_r  <= 1'b0;
    end else if (capture_s) begin
      held_valid_r <= 1'b1;
      pc_r         <= in_pc;
      rs1_data_r   <= in_rs1_data;
      rs2_data_r   <= in_rs2_data;
      imm_r        <= in_imm;
      rs1_addr_r   <= in_rs1_addr;
      rs2_addr_r   <= in_rs2_addr;
      rd_addr_r    <= in_rd_addr;
      func3_r      <= in_func3;
      func7_r      <= in_func7;
      a_sel_r      <= in_a_sel;
      b_sel_r      <= in_b_sel;
      reg_write_r  <= in_reg_write;
      mem_read_r   <= in_mem_read;
      mem_write_r  <= in_mem_write;
    end else begin
      if (flush || departure_s) begin
        held_valid_r <= 1'b0;
      end
      if (held_valid_r && !departure_s && wb_hit_rs1_s) begin
        rs1_data_r <= wb_result;
      end
      if (held_valid_r && !departure_s && wb_hit_rs2_s) begin
        rs2_data_r <= wb_result;
      end
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed-vector bench for id_ex_stage with hand-computed expectations.
module tb_id_ex_stage;

  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [63:0] in_pc, in_rs1_data, in_rs2_data, in_imm;
  logic [4:0]  in_rs1_addr, in_rs2_addr, in_rd_addr;
  logic [2:0]  in_func3;
  logic [6:0]  in_func7;
  logic        in_a_sel, in_b_sel, in_reg_write, in_mem_read, in_mem_write;
  logic        flush;
  logic        exm_valid, exm_reg_write, exm_mem_read;
  logic [4:0]  exm_rd_addr;
  logic [63:0] exm_result;
  logic        wb_valid, wb_reg_write;
  logic [4:0]  wb_rd_addr;
  logic [63:0] wb_result;
  logic        out_valid, out_ready;
  logic [63:0] data_rs1, data_rs2, store_data, pc;
  logic [2:0]  func3;
  logic [6:0]  func7;
  logic [4:0]  rd_addr;
  logic        reg_write, mem_read, mem_write;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.DATA_WIDTH(64), .REG_ADDR_W(5)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
    .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr), .in_rd_addr(in_rd_addr),
    .in_func3(in_func3), .in_func7(in_func7), .in_a_sel(in_a_sel), .in_b_sel(in_b_sel),
    .in_reg_write(in_reg_write), .in_mem_read(in_mem_read), .in_mem_write(in_mem_write),
    .flush(flush),
    .exm_valid(exm_valid), .exm_reg_write(exm_reg_write), .exm_mem_read(exm_mem_read),
    .exm_rd_addr(exm_rd_addr), .exm_result(exm_result),
    .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_rd_addr(wb_rd_addr),
    .wb_result(wb_result),
    .out_valid(out_valid), .out_ready(out_ready),
    .data_rs1(data_rs1), .data_rs2(data_rs2), .store_data(store_data),
    .func3(func3), .func7(func7), .rd_addr(rd_addr), .pc(pc),
    .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // advance one edge, then settle inputs 1 time unit after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_instr(input logic [63:0] ipc, input logic [4:0] rs1, input logic [63:0] d1,
                             input logic [4:0] rs2, input logic [63:0] d2, input logic [63:0] imm,
                             input logic [4:0] rd, input logic [2:0] f3, input logic [6:0] f7,
                             input logic asel, input logic bsel, input logic mw);
    in_valid = 1'b1; in_pc = ipc;
    in_rs1_addr = rs1; in_rs1_data = d1; in_rs2_addr = rs2; in_rs2_data = d2;
    in_imm = imm; in_rd_addr = rd; in_func3 = f3; in_func7 = f7;
    in_a_sel = asel; in_b_sel = bsel; in_mem_write = mw; in_reg_write = !mw; in_mem_read = 1'b0;
  endtask

  task automatic clear_fwd();
    exm_valid = 1'b0; exm_reg_write = 1'b0; exm_mem_read = 1'b0; exm_rd_addr = 5'd0; exm_result = 64'd0;
    wb_valid = 1'b0; wb_reg_write = 1'b0; wb_rd_addr = 5'd0; wb_result = 64'd0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
    drive_instr(64'd0, 5'd0, 64'd0, 5'd0, 64'd0, 64'd0, 5'd0, 3'd0, 7'd0, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b0; in_reg_write = 1'b0;
    clear_fwd();
    tick(); tick();
    rst = 1'b0;
    #1;
    check("reset_out_valid", {63'd0, out_valid}, 64'd0);
    check("reset_in_ready", {63'd0, in_ready}, 64'd1);
    check("reset_data_rs1", data_rs1, 64'd0);
    check("reset_pc", pc, 64'd0);

    // pass-through ADD
    drive_instr(64'h100, 5'd3, 64'd5, 5'd4, 64'd7, 64'd0, 5'd5, F3_ADD, F7_BASE, A_SEL_RS1, B_SEL_RS2, 1'b0);
    tick();
    in_valid = 1'b0;
    #1;
    check("pt_out_valid", {63'd0, out_valid}, 64'd1);
    check("pt_data_rs1", data_rs1, 64'd5);
    check("pt_data_rs2", data_rs2, 64'd7);
    check("pt_func3", {61'd0, func3}, 64'd0);
    check("pt_func7", {57'd0, func7}, 64'd0);
    check("pt_rd_addr", {59'd0, rd_addr}, 64'd5);
    check("pt_reg_write", {63'd0, reg_write}, 64'd1);

    // EX/MEM beats WB, then WB alone
    exm_valid = 1'b1; exm_reg_write = 1'b1; exm_rd_addr = 5'd3; exm_result = 64'h11;
    wb_valid = 1'b1; wb_reg_write = 1'b1; wb_rd_addr = 5'd3; wb_result = 64'h22;
    #1 check("prio_exm", data_rs1, 64'h11);
    exm_valid = 1'b0;
    #1 check("prio_wb", data_rs1, 64'h22);
    clear_fwd();
    #1 check("prio_none", data_rs1, 64'd5);
    tick();
    check("depart_out_valid", {63'd0, out_valid}, 64'd0);

    // x0 never forwarded, immediate select
    drive_instr(64'h104, 5'd0, 64'h55, 5'd4, 64'd7, 64'd8, 5'd6, F3_ADD, F7_BASE, A_SEL_RS1, B_SEL_IMM, 1'b0);
    tick();
    in_valid = 1'b0;
    exm_valid = 1'b1; exm_reg_write = 1'b1; exm_rd_addr = 5'd0; exm_result = 64'hFF;
    #1;
    check("x0_data_rs1", data_rs1, 64'd0);
    check("imm_data_rs2", data_rs2, 64'd8);
    check("imm_store_data", store_data, 64'd7);
    clear_fwd();
    tick();

    // load-use stall on rs2, resolved via WB
    drive_instr(64'h108, 5'd1, 64'h1, 5'd6, 64'h33, 64'd0, 5'd7, F3_XOR, F7_BASE, A_SEL_RS1, B_SEL_RS2, 1'b0);
    tick();
    in_valid = 1'b0;
    exm_valid = 1'b1; exm_reg_write = 1'b1; exm_mem_read = 1'b1; exm_rd_addr = 5'd6; exm_result = 64'hDEAD;
    #1;
    check("lu_out_valid", {63'd0, out_valid}, 64'd0);
    check("lu_in_ready", {63'd0, in_ready}, 64'd0);
    tick();
    clear_fwd();
    wb_valid = 1'b1; wb_reg_write = 1'b1; wb_rd_addr = 5'd6; wb_result = 64'h40;
    #1;
    check("lu_release_valid", {63'd0, out_valid}, 64'd1);
    check("lu_data_rs2", data_rs2, 64'h40);
    check("lu_func3", {61'd0, func3}, {61'd0, F3_XOR});
    tick();
    clear_fwd();

    // store: rs2 counts as used even with immediate b operand
    drive_instr(64'h10C, 5'd9, 64'h9, 5'd10, 64'hA, 64'h10, 5'd0, F3_SLT, F7_BASE, A_SEL_RS1, B_SEL_IMM, 1'b1);
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    exm_valid = 1'b1; exm_reg_write = 1'b1; exm_mem_read = 1'b1; exm_rd_addr = 5'd10;
    #1 check("store_hazard", {63'd0, out_valid}, 64'd0);
    clear_fwd();
    out_ready = 1'b1;
    tick();

    // a_sel=PC: rs1 load match is not a hazard
    drive_instr(64'h200, 5'd9, 64'h9, 5'd11, 64'hB, 64'h4, 5'd1, F3_ADD, F7_BASE, A_SEL_PC, B_SEL_IMM, 1'b0);
    tick();
    in_valid = 1'b0;
    exm_valid = 1'b1; exm_reg_write = 1'b1; exm_mem_read = 1'b1; exm_rd_addr = 5'd9;
    #1;
    check("pcsel_no_hazard", {63'd0, out_valid}, 64'd1);
    check("pcsel_data_rs1", data_rs1, 64'h200);
    clear_fwd();
    tick();

    // back-pressure with WB refresh of rs1
    drive_instr(64'h300, 5'd7, 64'h70, 5'd8, 64'h80, 64'd0, 5'd12, F3_OR, F7_ALT, A_SEL_RS1, B_SEL_RS2, 1'b0);
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    wb_valid = 1'b1; wb_reg_write = 1'b1; wb_rd_addr = 5'd7; wb_result = 64'h99;
    tick();
    clear_fwd();
    #1;
    check("bp_out_valid", {63'd0, out_valid}, 64'd1);
    check("bp_in_ready", {63'd0, in_ready}, 64'd0);
    tick();
    tick();
    out_ready = 1'b1;
    #1;
    check("bp_data_rs1", data_rs1, 64'h99);
    check("bp_data_rs2", data_rs2, 64'h80);
    check("bp_func3", {61'd0, func3}, {61'd0, F3_OR});
    check("bp_func7", {57'd0, func7}, {57'd0, F7_ALT});
    check("bp_pc", pc, 64'h300);
    check("bp_rd_addr", {59'd0, rd_addr}, 64'd12);
    check("bp_in_ready_release", {63'd0, in_ready}, 64'd1);

    // back-to-back capture on departure
    drive_instr(64'h400, 5'd2, 64'h2, 5'd3, 64'h3, 64'd0, 5'd4, F3_AND, F7_BASE, A_SEL_RS1, B_SEL_RS2, 1'b0);
    tick();
    in_valid = 1'b0;
    out_ready = 1'b0;
    #1;
    check("b2b_out_valid", {63'd0, out_valid}, 64'd1);
    check("b2b_pc", pc, 64'h400);

    // flush beats a simultaneous capture
    drive_instr(64'h500, 5'd2, 64'h2, 5'd3, 64'h3, 64'd0, 5'd4, F3_SLL, F7_BASE, A_SEL_RS1, B_SEL_RS2, 1'b0);
    flush = 1'b1;
    #1 check("flush_in_ready", {63'd0, in_ready}, 64'd0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    check("flush_out_valid", {63'd0, out_valid}, 64'd0);
    check("flush_no_capture_pc", pc, 64'h400);
    check("flush_in_ready_after", {63'd0, in_ready}, 64'd1);

    // asynchronous reset in the middle of a load-use stall
    out_ready = 1'b1;
    drive_instr(64'h600, 5'd13, 64'h13, 5'd14, 64'h14, 64'd0, 5'd15, F3_SRL, F7_ALT, A_SEL_RS1, B_SEL_RS2, 1'b0);
    tick();
    in_valid = 1'b0;
    exm_valid = 1'b1; exm_reg_write = 1'b1; exm_mem_read = 1'b1; exm_rd_addr = 5'd13;
    #1 check("rst_pre_stall", {63'd0, out_valid}, 64'd0);
    #1 rst = 1'b1;
    #1;
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_pc", pc, 64'd0);
    check("rst_func7", {57'd0, func7}, 64'd0);
    check("rst_data_rs2", data_rs2, 64'd0);
    check("rst_reg_write", {63'd0, reg_write}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
